// File: rtl/serial_word_pkg.sv
// Shared types and line-level constants for the serial word receiver.
// Used by serial_word_rx (parity stage enabled by SERIAL_WORD_RX_PARITY_CHECK_EN).
package serial_word_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_e;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/shift_in_reg.sv
// Directional serial shift-in register: LSB-first enters at the MSB,
// MSB-first enters at bit 0. No parallel load.
module shift_in_reg
   import serial_word_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] msb_first_c;
   logic [WIDTH-1:0] lsb_first_c;

   // A one-bit register has nothing to shift; it just captures sin.
   generate
      if (WIDTH == 1) begin : g_one
         assign msb_first_c = sin;
         assign lsb_first_c = sin;
      end else begin : g_multi
         assign msb_first_c = {value[WIDTH-2:0], sin};
         assign lsb_first_c = {sin, value[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (shift_en) begin
         value <= (dir == DIR_MSB_FIRST) ? msb_first_c : lsb_first_c;
      end
   end

endmodule

// File: rtl/serial_word_rx.sv
// Framed serial-to-parallel receiver driven by an upstream bit strobe.
// Define SERIAL_WORD_RX_PARITY_CHECK_EN to expect an even-parity bit before the stop bit.
module serial_word_rx
   import serial_word_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             bit_en,
   input  logic             sin,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             frame_err,
   output logic             parity_err,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dir_lat, dir_lat_nxt;
   logic [WIDTH-1:0] sreg, q_nxt;
   logic             q_valid_nxt, frame_err_nxt, busy_nxt;
   logic             shift_en_c, clr_c;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
   logic             par_ok, par_ok_nxt;
   logic             parity_err_nxt;
`endif

   shift_in_reg #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (clr_c),
      .shift_en (shift_en_c),
      .dir      (dir_lat),
      .sin      (sin),
      .value    (sreg)
   );

   // Frame sequencing; nothing advances without a strobe, pulses default low.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      dir_lat_nxt   = dir_lat;
      q_nxt         = q;
      q_valid_nxt   = 1'b0;
      frame_err_nxt = 1'b0;
      shift_en_c    = 1'b0;
      clr_c         = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      par_ok_nxt     = par_ok;
      parity_err_nxt = 1'b0;
`endif
      if (bit_en) begin
         case (state)
            IDLE: begin
               if (sin == START_LEVEL) begin
                  state_nxt   = DATA;
                  dir_lat_nxt = dir;
                  cnt_nxt     = '0;
                  clr_c       = 1'b1;
               end
            end
            DATA: begin
               shift_en_c = 1'b1;
               cnt_nxt    = cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
            PARITY: begin
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
               par_ok_nxt = (sin == ^sreg);
`endif
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (sin != IDLE_LEVEL) begin
                  frame_err_nxt = 1'b1;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
               end else if (!par_ok) begin
                  parity_err_nxt = 1'b1;
`endif
               end else begin
                  q_nxt       = sreg;
                  q_valid_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         dir_lat   <= DIR_LSB_FIRST;
         q         <= '0;
         q_valid   <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         dir_lat   <= dir_lat_nxt;
         q         <= q_nxt;
         q_valid   <= q_valid_nxt;
         frame_err <= frame_err_nxt;
         busy      <= busy_nxt;
      end
   end

`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         par_ok     <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_ok     <= par_ok_nxt;
         parity_err <= parity_err_nxt;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomised frame-level bench for serial_word_rx with a per-cycle output model.
// Build with SERIAL_WORD_RX_PARITY_CHECK_EN defined to exercise the parity stage.
module tb_serial_word_rx;

   localparam int unsigned WIDTH = 4;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic             clk    = 1'b0;
   logic             resetn = 1'b0;
   logic             bit_en = 1'b0;
   logic             sin    = 1'b1;
   logic             dir    = 1'b0;
   logic [WIDTH-1:0] q;
   logic             q_valid, frame_err, parity_err, busy;

   serial_word_rx #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bit_en     (bit_en),
      .sin        (sin),
      .dir        (dir),
      .q          (q),
      .q_valid    (q_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: what each output must show after the most recent edge.
   logic [WIDTH-1:0] exp_q     = '0;
   logic             exp_valid = 1'b0;
   logic             exp_ferr  = 1'b0;
   logic             exp_perr  = 1'b0;
   logic             exp_busy  = 1'b0;
   bit               cmp_en    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("q",          32'(q),          32'(exp_q));
         chk("q_valid",    32'(q_valid),    32'(exp_valid));
         chk("frame_err",  32'(frame_err),  32'(exp_ferr));
         chk("parity_err", 32'(parity_err), 32'(exp_perr));
         chk("busy",       32'(busy),       32'(exp_busy));
      end
   end

   // One clock: drive inputs, let the edge happen, pulses from older edges expire.
   task automatic step(input logic en, input logic s, input logic d);
      bit_en = en;
      sin    = s;
      dir    = d;
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_perr  = 1'b0;
   endtask

   // Strobe-free cycles with junk on sin/dir.
   task automatic gap(input int maxgap);
      int n;
      n = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom));
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input logic d, input logic stop_b,
                             input logic par_b, input int maxgap, input bit rand_dir);
      logic b;
      gap(maxgap);
      step(1'b1, 1'b0, d);
      exp_busy = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         gap(maxgap);
         b = d ? w[int'(WIDTH) - 1 - i] : w[i];
         step(1'b1, b, rand_dir ? 1'($urandom) : d);
      end
      if (PAR_EN) begin
         gap(maxgap);
         step(1'b1, par_b, 1'($urandom));
      end
      gap(maxgap);
      step(1'b1, stop_b, 1'($urandom));
      exp_busy = 1'b0;
      if (!stop_b) begin
         exp_ferr = 1'b1;
      end else if (PAR_EN && (par_b != ^w)) begin
         exp_perr = 1'b1;
      end else begin
         exp_q     = w;
         exp_valid = 1'b1;
      end
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      #2;
      chk("reset_q",    32'(q),       32'h0);
      chk("reset_busy", 32'(busy),    32'h0);
      chk("reset_qv",   32'(q_valid), 32'h0);
      cmp_en = 1'b1;
      repeat (2) step(1'b0, 1'b1, 1'b0);
      resetn = 1'b1;
      repeat (3) step(1'b1, 1'b1, 1'b0);

      // Aborted frame: start + two data bits, then reset.
      step(1'b1, 1'b0, 1'b0);
      exp_busy = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      resetn   = 1'b0;
      exp_busy = 1'b0;
      exp_q    = '0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      resetn = 1'b1;
      step(1'b0, 1'b1, 1'b0);

      send_frame(4'hB, 1'b0, 1'b1, ^(4'hB), 3, 1'b0);
      chk("lit_lsb_B", 32'(q), 32'hB);
      chk("lit_lsb_B_qv", 32'(q_valid), 32'h1);

      send_frame(4'hD, 1'b1, 1'b1, ^(4'hD), 2, 1'b0);
      chk("lit_msb_D", 32'(q), 32'hD);
      send_frame(4'hD, 1'b1, 1'b1, ^(4'hD), 2, 1'b1);
      chk("lit_msb_D_dir_toggle", 32'(q), 32'hD);

      send_frame(4'hB, 1'b0, 1'b1, ^(4'hB), 1, 1'b0);
      send_frame(4'h4, 1'b0, 1'b0, ^(4'h4), 5, 1'b0);
      chk("lit_ferr_keep_B", 32'(q), 32'hB);
      chk("lit_ferr_pulse", 32'(frame_err), 32'h1);
      chk("lit_ferr_no_qv", 32'(q_valid), 32'h0);

      send_frame(4'h5, 1'b0, 1'b1, ^(4'h5), 0, 1'b0);
      chk("lit_b2b_5", 32'(q), 32'h5);
      send_frame(4'hA, 1'b0, 1'b1, ^(4'hA), 0, 1'b0);
      chk("lit_b2b_A", 32'(q), 32'hA);

`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      send_frame(4'h7, 1'b0, 1'b1, 1'b1, 2, 1'b0);
      chk("lit_par_ok_7", 32'(q), 32'h7);
      send_frame(4'h7, 1'b1, 1'b1, 1'b0, 2, 1'b0);
      chk("lit_par_bad_keep_7", 32'(q), 32'h7);
      chk("lit_par_bad_pulse", 32'(parity_err), 32'h1);
`endif

      for (int k = 0; k < 60; k++) begin
         w = WIDTH'($urandom);
         send_frame(w, 1'($urandom), ($urandom_range(4, 0) != 0),
                    (^w) ^ ($urandom_range(3, 0) == 0), 5, 1'b1);
         if ($urandom_range(2, 0) == 0) step(1'b1, 1'b1, 1'($urandom));
      end
      repeat (3) step(1'b0, 1'b1, 1'b0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
